// File: rtl/iob_sp_ram_be_initiator_pkg.sv
// Shared definitions for the byte-enable RAM initiator: FSM state encoding
// and the byte-lane count helper.
package iob_sp_ram_be_initiator_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Number of byte lanes in a data word.
    function automatic int nbytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_sync_fifo_resp.sv
// Synchronous in-order FIFO holding read responses. DEPTH need not be a
// power of two, so pointers wrap on an explicit compare. The head output
// reads as zero while the FIFO is empty so no stale word is ever exposed.
module iob_sync_fifo_resp #(
    parameter int DEPTH = 3,
    parameter int W     = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign dout   = empty ? '0 : mem[rd_ptr];

    // Storage write; data is not reset, only the pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iob_sp_ram_be_initiator.sv
// Initiator for a single-port byte-enable RAM with 1-cycle registered read.
// Turns a valid/ready request channel into RAM cycles and returns read data
// in order through a small response FIFO that absorbs back-pressure.
// Optional power-up clear sweep: define IOB_SP_RAM_BE_INITIATOR_CLEAR_EN.
module iob_sp_ram_be_initiator
    import iob_sp_ram_be_initiator_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RESP_DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                busy,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
);

    localparam int NBYTES = nbytes(DATA_W);
    localparam int CW     = $clog2(RESP_DEPTH + 1);

    state_t        state;
    state_t        state_nxt;
    logic          rd_pend;
    logic [CW-1:0] count;
    logic          empty;
    logic [CW:0]   occ;
    logic          acc;
    logic          rd_acc;

    // Occupancy counts buffered words plus the read whose data arrives next
    // cycle; it ignores a same-cycle pop so req_ready never depends on
    // resp_ready combinationally.
    assign occ       = {1'b0, count} + (CW + 1)'(rd_pend);
    assign req_ready = !rst && (state == ST_RUN) && (occ < (CW + 1)'(RESP_DEPTH));
    assign acc       = req_valid && req_ready;
    assign rd_acc    = acc && (req_wstrb == '0);

`ifdef IOB_SP_RAM_BE_INITIATOR_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;

    // Clear sweep address, one word per cycle, restarting on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // State register: reset starts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR once the last address has been written.
    always_comb begin
        state_nxt = state;
        if ((state == ST_CLEAR) && (clr_addr == '1)) begin
            state_nxt = ST_RUN;
        end
    end

    assign busy = (state == ST_CLEAR);
`else
    // State register: without the clear sweep the block always runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: RUN is the only reachable state.
    always_comb begin
        state_nxt = ST_RUN;
    end

    assign busy = 1'b0;
`endif

    // RAM port drive: accepted request passes straight through, or the
    // clear sweep owns the port.
    always_comb begin
        ram_en   = acc;
        ram_we   = acc ? req_wstrb : {NBYTES{1'b0}};
        ram_addr = req_addr;
        ram_din  = req_wdata;
`ifdef IOB_SP_RAM_BE_INITIATOR_CLEAR_EN
        if ((state == ST_CLEAR) && !rst) begin
            ram_en   = 1'b1;
            ram_we   = {NBYTES{1'b1}};
            ram_addr = clr_addr;
            ram_din  = '0;
        end
`endif
    end

    // Read in flight: RAM data is valid the cycle after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_acc;
        end
    end

    iob_sync_fifo_resp #(
        .DEPTH (RESP_DEPTH),
        .W     (DATA_W)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend),
        .pop   (resp_ready),
        .din   (ram_dout),
        .dout  (resp_rdata),
        .empty (empty),
        .count (count)
    );

    assign resp_valid = !empty;

endmodule
